alu_issue_ctrl: RTL

//  Sequential issue/writeback controller that drives the 2-bit-op ALU (add/sub/lui/or) from the operand side.

---
 rtl/alu_issue_ctrl_pkg.sv | 39 +++
 rtl/alu_issue_ctrl_imm_ext.sv | 13 +
 rtl/alu_issue_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: micro-op codes, ALU op codes,
// FSM states and response memory codes.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] OP_ADDU = 3'd0;
  localparam logic [2:0] OP_SUBU = 3'd1;
  localparam logic [2:0] OP_LUI  = 3'd2;
  localparam logic [2:0] OP_ORI  = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_LUI = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic writes_reg(input logic [2:0] op);
    return (op == OP_ADDU) || (op == OP_SUBU) || (op == OP_LUI) || (op == OP_ORI);
  endfunction

  function automatic logic [1:0] mem_code(input logic [2:0] op);
    if (op == OP_LW) return MEM_LOAD;
    if (op == OP_SW) return MEM_STORE;
    return MEM_NONE;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_imm_ext.sv
// Immediate extender: widens an IMM_W immediate to W bits, sign- or zero-extended.
module alu_imm_ext #(
  parameter int W     = 32,
  parameter int IMM_W = 16
) (
  input  logic [IMM_W-1:0] imm,
  input  logic             sign_ext,
  output logic [W-1:0]     ext
);

  assign ext = {{(W-IMM_W){sign_ext & imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving a 2-bit-op ALU over req/rsp valid-ready handshakes.
// Optional build macro ALU_ISSUE_STATS_EN adds the stat_ops/stat_taken counters.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int W     = 32,
  parameter int IMM_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [W-1:0]     req_rs,
  input  logic [W-1:0]     req_rt,
  input  logic [IMM_W-1:0] req_imm,
  input  logic [4:0]       req_rd,
  output logic [W-1:0]     alu_operand1,
  output logic [W-1:0]     alu_operand2,
  output logic [1:0]       alu_operation,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic [4:0]       rsp_rd,
  output logic             rsp_wen,
  output logic [1:0]       rsp_mem,
  output logic             rsp_taken,
  output logic             rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_taken
`endif
);

  state_t         state, state_nxt;
  logic           accept, rsp_fire;
  logic [2:0]     op_q;
  logic [4:0]     rd_q;
  logic [W-1:0]   imm_ext;
  logic [W-1:0]   op1_nxt, op2_nxt;
  logic [1:0]     aluop_nxt;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  alu_imm_ext #(.W(W), .IMM_W(IMM_W)) u_imm_ext (
    .imm      (req_imm),
    .sign_ext ((req_op == OP_LW) || (req_op == OP_SW)),
    .ext      (imm_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op1_nxt   = '0;
    op2_nxt   = '0;
    aluop_nxt = ALU_ADD;
    case (req_op)
      OP_ADDU:      begin op1_nxt = req_rs; op2_nxt = req_rt;  aluop_nxt = ALU_ADD; end
      OP_SUBU,
      OP_BEQ:       begin op1_nxt = req_rs; op2_nxt = req_rt;  aluop_nxt = ALU_SUB; end
      OP_LUI:       begin op1_nxt = '0;     op2_nxt = imm_ext; aluop_nxt = ALU_LUI; end
      OP_ORI:       begin op1_nxt = req_rs; op2_nxt = imm_ext; aluop_nxt = ALU_OR;  end
      OP_LW, OP_SW: begin op1_nxt = req_rs; op2_nxt = imm_ext; aluop_nxt = ALU_ADD; end
      default:      ;
    endcase
  end

  // Accept edge: latch the micro-op and present operands to the ALU
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= '0;
      rd_q          <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      alu_operation <= '0;
    end else if (accept) begin
      op_q          <= req_op;
      rd_q          <= req_rd;
      alu_operand1  <= op1_nxt;
      alu_operand2  <= op2_nxt;
      alu_operation <= aluop_nxt;
    end
  end

  // End of EXEC: capture the ALU output into the held response
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result  <= '0;
      rsp_rd      <= '0;
      rsp_wen     <= 1'b0;
      rsp_mem     <= MEM_NONE;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result  <= alu_result;
      rsp_rd      <= rd_q;
      rsp_wen     <= writes_reg(op_q);
      rsp_mem     <= mem_code(op_q);
      rsp_taken   <= (op_q == OP_BEQ) && alu_zero;
      rsp_illegal <= (op_q == OP_ILL);
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops   <= '0;
      stat_taken <= '0;
    end else if (rsp_fire) begin
      stat_ops <= stat_ops + 1'b1;
      if (rsp_taken) stat_taken <= stat_taken + 1'b1;
    end
  end
`endif

endmodule
